// File: rtl/ysyx_23060072_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060072_if_stage
// Purpose  : rv32e instruction fetch with a single-outstanding req/gnt/rvalid
//            bus, redirect handling and the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060072_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        if_hold_flag_i,
  input  logic        clean_flag_i,
  input  logic        timer_interrupt_i,
  output logic        ifu_req_o,
  output logic [31:0] ifu_addr_o,
  input  logic        ifu_gnt_i,
  input  logic        ifu_rvalid_i,
  input  logic [31:0] ifu_rdata_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        timer_interrupt_o,
  output logic        if_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic        r_discard, w_discard_nxt;
  logic        r_pend, w_pend_nxt;
  logic [31:0] r_pend_addr, w_pend_addr_nxt;
  logic [31:0] r_buf_instr, r_buf_pc;
  logic        w_buf_load;
  logic        w_deliver;
  logic [31:0] w_del_instr, w_del_pc;
  logic [31:0] w_jump_tgt, w_pc_inc;

  logic [31:0] r_instr, r_pc;
  logic        r_valid, r_tirq;

  assign w_jump_tgt = jump_addr_i & 32'hFFFF_FFFC;
  assign w_pc_inc   = r_fetch_pc + 32'd4;

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_discard_nxt   = r_discard;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_buf_load      = 1'b0;
    w_deliver       = 1'b0;
    w_del_instr     = r_buf_instr;
    w_del_pc        = r_buf_pc;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (jump_flag_i) w_fetch_pc_nxt = w_jump_tgt;
      end
      S_REQ: begin
        if (ifu_gnt_i) begin
          w_state_nxt = S_RESP;
          w_pend_nxt  = 1'b0;
          // The granted request belongs to the old path once any redirect is seen
          if (jump_flag_i) begin
            w_discard_nxt  = 1'b1;
            w_fetch_pc_nxt = w_jump_tgt;
          end else if (r_pend) begin
            w_discard_nxt  = 1'b1;
            w_fetch_pc_nxt = r_pend_addr;
          end
        end else if (jump_flag_i) begin
          w_pend_nxt      = 1'b1;
          w_pend_addr_nxt = w_jump_tgt;
        end
      end
      S_RESP: begin
        if (jump_flag_i) begin
          w_fetch_pc_nxt = w_jump_tgt;
          if (ifu_rvalid_i) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end else if (ifu_rvalid_i) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else if (!if_hold_flag_i) begin
            w_deliver      = 1'b1;
            w_del_instr    = ifu_rdata_i;
            w_del_pc       = r_fetch_pc;
            w_fetch_pc_nxt = w_pc_inc;
            w_state_nxt    = S_REQ;
          end else begin
            w_buf_load  = 1'b1;
            w_state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (jump_flag_i) begin
          w_fetch_pc_nxt = w_jump_tgt;
          w_state_nxt    = S_REQ;
        end else if (!if_hold_flag_i) begin
          w_deliver      = 1'b1;
          w_fetch_pc_nxt = w_pc_inc;
          w_state_nxt    = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_discard   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= 32'd0;
      r_buf_instr <= 32'd0;
      r_buf_pc    <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_discard   <= w_discard_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      if (w_buf_load) begin
        r_buf_instr <= ifu_rdata_i;
        r_buf_pc    <= r_fetch_pc;
      end
    end
  end

  // IF/ID register: a bubble never carries the timer interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'd0;
      r_valid <= 1'b0;
      r_tirq  <= 1'b0;
    end else if (clean_flag_i) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_tirq  <= 1'b0;
    end else if (!if_hold_flag_i) begin
      if (w_deliver) begin
        r_instr <= w_del_instr;
        r_pc    <= w_del_pc;
        r_valid <= 1'b1;
        r_tirq  <= timer_interrupt_i;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
        r_tirq  <= 1'b0;
      end
    end
  end

  assign ifu_req_o         = (r_state == S_REQ);
  assign ifu_addr_o        = r_fetch_pc & 32'hFFFF_FFFC;
  assign instr_rdata_o     = r_instr;
  assign pc_o              = r_pc;
  assign instr_valid_o     = r_valid;
  assign timer_interrupt_o = r_tirq;
  assign if_busy_o         = (r_state != S_FULL);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060072_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060072_if_stage
// Purpose  : cycle-accurate directed vectors plus a zero-wait memory sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060072_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NV  = 39;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        if_hold_flag_i;
  logic        clean_flag_i;
  logic        timer_interrupt_i;
  logic        ifu_req_o;
  logic [31:0] ifu_addr_o;
  logic        ifu_gnt_i;
  logic        ifu_rvalid_i;
  logic [31:0] ifu_rdata_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        timer_interrupt_o;
  logic        if_busy_o;

  ysyx_23060072_if_stage dut (
    .clk               (clk),
    .rst               (rst),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i),
    .if_hold_flag_i    (if_hold_flag_i),
    .clean_flag_i      (clean_flag_i),
    .timer_interrupt_i (timer_interrupt_i),
    .ifu_req_o         (ifu_req_o),
    .ifu_addr_o        (ifu_addr_o),
    .ifu_gnt_i         (ifu_gnt_i),
    .ifu_rvalid_i      (ifu_rvalid_i),
    .ifu_rdata_i       (ifu_rdata_i),
    .instr_rdata_o     (instr_rdata_o),
    .pc_o              (pc_o),
    .instr_valid_o     (instr_valid_o),
    .timer_interrupt_o (timer_interrupt_o),
    .if_busy_o         (if_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, jmp;
    logic [31:0] jaddr;
    logic        hold, clean, tirq, gnt, rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr, instr, pc;
    logic        valid, tio, busy;
  } vec_t;

  vec_t vecs [NV];
  int   n_applied;
  int   n_miscmp;

  function automatic vec_t mk(
    input logic r, input logic j, input logic [31:0] ja,
    input logic h, input logic c, input logic t, input logic g, input logic v,
    input logic [31:0] d,
    input logic eq, input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
    input logic ev, input logic et, input logic eb);
    vec_t x;
    x.rst = r; x.jmp = j; x.jaddr = ja; x.hold = h; x.clean = c; x.tirq = t;
    x.gnt = g; x.rvalid = v; x.rdata = d;
    x.req = eq; x.addr = ea; x.instr = ei; x.pc = ep; x.valid = ev; x.tio = et; x.busy = eb;
    return x;
  endfunction

  task automatic check(input string name, input logic eq, input logic [31:0] ea,
                       input logic [31:0] ei, input logic [31:0] ep,
                       input logic ev, input logic et, input logic eb);
    n_applied++;
    if (ifu_req_o !== eq || ifu_addr_o !== ea || instr_rdata_o !== ei || pc_o !== ep ||
        instr_valid_o !== ev || timer_interrupt_o !== et || if_busy_o !== eb) begin
      n_miscmp++;
      $display("FAIL %s: got req=%b addr=%h instr=%h pc=%h valid=%b tirq=%b busy=%b, want req=%b addr=%h instr=%h pc=%h valid=%b tirq=%b busy=%b",
               name, ifu_req_o, ifu_addr_o, instr_rdata_o, pc_o, instr_valid_o,
               timer_interrupt_o, if_busy_o, eq, ea, ei, ep, ev, et, eb);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
    n_applied++;
    if (got !== want) begin
      n_miscmp++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    logic        issued, next_issued;
    logic [31:0] issued_addr, next_addr, exp_pc;
    int          n_valid;

    n_applied = 0;
    n_miscmp  = 0;
    //             r  j  jaddr         h  c  t  g  v  rdata          req addr          instr          pc             v  ti busy
    vecs[0]  = mk(1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         0, 32'h8000_0000, NOP,          32'h0,         0, 0, 1);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         1, 32'h8000_0000, NOP,          32'h0,         0, 0, 1);
    vecs[2]  = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h8000_0000, NOP,          32'h0,         0, 0, 1);
    vecs[3]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0050_0093, 1, 32'h8000_0004, 32'h0050_0093, 32'h8000_0000, 1, 0, 1);
    vecs[4]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         1, 32'h8000_0004, NOP,          32'h8000_0000, 0, 0, 1);
    vecs[5]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         1, 32'h8000_0004, NOP,          32'h8000_0000, 0, 0, 1);
    vecs[6]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         1, 32'h8000_0004, NOP,          32'h8000_0000, 0, 0, 1);
    vecs[7]  = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h8000_0004, NOP,          32'h8000_0000, 0, 0, 1);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         0, 32'h8000_0004, NOP,          32'h8000_0000, 0, 0, 1);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0, 1, 0, 1, 32'h0010_0113, 1, 32'h8000_0008, 32'h0010_0113, 32'h8000_0004, 1, 1, 1);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h8000_0008, NOP,          32'h8000_0004, 0, 0, 1);
    vecs[11] = mk(0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h0020_8193, 0, 32'h8000_0008, NOP,          32'h8000_0004, 0, 0, 0);
    vecs[12] = mk(0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,         0, 32'h8000_0008, NOP,          32'h8000_0004, 0, 0, 0);
    vecs[13] = mk(0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,         1, 32'h8000_000C, 32'h0020_8193, 32'h8000_0008, 1, 1, 1);
    vecs[14] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h8000_000C, NOP,          32'h8000_0008, 0, 0, 1);
    vecs[15] = mk(0, 1, 32'h8000_0100, 0, 0, 0, 0, 0, 32'h0,        0, 32'h8000_0100, NOP,          32'h8000_0008, 0, 0, 1);
    vecs[16] = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         0, 32'h8000_0100, NOP,          32'h8000_0008, 0, 0, 1);
    vecs[17] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h8000_0100, NOP,          32'h8000_0008, 0, 0, 1);
    vecs[18] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h8000_0100, NOP,          32'h8000_0008, 0, 0, 1);
    vecs[19] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0030_0213, 1, 32'h8000_0104, 32'h0030_0213, 32'h8000_0100, 1, 0, 1);
    vecs[20] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h8000_0104, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[21] = mk(0, 1, 32'h8000_0200, 0, 0, 0, 0, 1, 32'hBAD0_0001, 1, 32'h8000_0200, NOP,         32'h8000_0100, 0, 0, 1);
    vecs[22] = mk(0, 1, 32'h8000_0300, 0, 0, 0, 0, 0, 32'h0,        1, 32'h8000_0200, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[23] = mk(0, 1, 32'h8000_0102, 0, 0, 0, 0, 0, 32'h0,        1, 32'h8000_0200, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[24] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h8000_0100, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[25] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hBAD0_0002, 1, 32'h8000_0100, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[26] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h8000_0100, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[27] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0040_0293, 1, 32'h8000_0104, 32'h0040_0293, 32'h8000_0100, 1, 0, 1);
    vecs[28] = mk(0, 0, 32'h0,        1, 1, 1, 0, 0, 32'h0,         1, 32'h8000_0104, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[29] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 0, 32'h0,        0, 32'hFFFF_FFFC, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[30] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hBAD0_0003, 1, 32'hFFFF_FFFC, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[31] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'hFFFF_FFFC, NOP,          32'h8000_0100, 0, 0, 1);
    vecs[32] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0000_0513, 1, 32'h0000_0000, 32'h0000_0513, 32'hFFFF_FFFC, 1, 0, 1);
    vecs[33] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0000, NOP,          32'hFFFF_FFFC, 0, 0, 1);
    vecs[34] = mk(0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h0060_0313, 0, 32'h0000_0000, NOP,          32'hFFFF_FFFC, 0, 0, 0);
    vecs[35] = mk(0, 1, 32'h8000_0400, 1, 0, 0, 0, 0, 32'h0,        1, 32'h8000_0400, NOP,          32'hFFFF_FFFC, 0, 0, 1);
    vecs[36] = mk(0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,         0, 32'h8000_0400, NOP,          32'hFFFF_FFFC, 0, 0, 1);
    vecs[37] = mk(1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         0, 32'h8000_0000, NOP,          32'h0,         0, 0, 1);
    vecs[38] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hBAD0_0004, 1, 32'h8000_0000, NOP,          32'h0,         0, 0, 1);

    for (int i = 0; i < NV; i++) begin
      rst               = vecs[i].rst;
      jump_flag_i       = vecs[i].jmp;
      jump_addr_i       = vecs[i].jaddr;
      if_hold_flag_i    = vecs[i].hold;
      clean_flag_i      = vecs[i].clean;
      timer_interrupt_i = vecs[i].tirq;
      ifu_gnt_i         = vecs[i].gnt;
      ifu_rvalid_i      = vecs[i].rvalid;
      ifu_rdata_i       = vecs[i].rdata;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].instr, vecs[i].pc,
            vecs[i].valid, vecs[i].tio, vecs[i].busy);
    end

    // Zero-wait memory: grant every request at once, answer on the next cycle
    rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = 32'h0; if_hold_flag_i = 1'b0;
    clean_flag_i = 1'b0; timer_interrupt_i = 1'b0;
    ifu_gnt_i = 1'b0; ifu_rvalid_i = 1'b0; ifu_rdata_i = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issued = 1'b0;
    issued_addr = 32'h0;
    next_addr = 32'h0;
    exp_pc = 32'h8000_0000;
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      ifu_gnt_i    = ifu_req_o;
      ifu_rvalid_i = issued;
      ifu_rdata_i  = issued ? (issued_addr ^ 32'h1234_5000) : 32'h0;
      next_issued  = ifu_req_o;
      if (ifu_req_o) next_addr = ifu_addr_o;
      @(posedge clk);
      #1;
      issued      = next_issued;
      issued_addr = next_addr;
      if (instr_valid_o) begin
        check_word($sformatf("stream_pc%0d", n_valid), pc_o, exp_pc);
        check_word($sformatf("stream_instr%0d", n_valid), instr_rdata_o, exp_pc ^ 32'h1234_5000);
        exp_pc = exp_pc + 32'd4;
        n_valid++;
      end
    end
    check_word("stream_count", n_valid, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060072_if_stage.md
Name: ysyx_23060072_if_stage

Overview:
Instruction-fetch stage of the rv32e pipeline. It sits directly upstream of the decode stage and owns the fetch PC. It issues word fetches over a single-outstanding req/gnt/rvalid instruction bus. Fetched instructions go into the IF/ID pipeline register, which is controlled by the controller's hold, clean and jump signals.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven to decode when no valid instruction is present

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
jump_flag_i  input  1  redirect request from ex/controller (branch, jump, trap, mret)
jump_addr_i  input  32  redirect target, valid when jump_flag_i=1
if_hold_flag_i  input  1  stall: freeze the IF/ID register and do not advance the PC
clean_flag_i  input  1  flush: load NOP_INSTR into the IF/ID register
timer_interrupt_i  input  1  raw timer interrupt from clint
ifu_req_o  output  1  fetch request
ifu_addr_o  output  32  fetch address; word aligned
ifu_gnt_i  input  1  request accepted this cycle
ifu_rvalid_i  input  1  response data valid
ifu_rdata_i  input  32  response instruction word
instr_rdata_o  output  32  instruction to decode
pc_o  output  32  PC of instr_rdata_o
instr_valid_o  output  1  instr_rdata_o is a real fetched instruction
timer_interrupt_o  output  1  registered timer interrupt, aligned with instr_rdata_o
if_busy_o  output  1  fetch outstanding or no instruction buffered (controller stall hint)

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, state=IDLE, ifu_req_o=0, instr_rdata_o=NOP_INSTR, pc_o=0, instr_valid_o=0, timer_interrupt_o=0, discard flag=0, pending-redirect=0, buffer empty. Reset asserted mid-transaction abandons the transaction. After reset, any late rvalid for the abandoned request is ignored because state is IDLE.
- FSM states: IDLE, REQ, RESP, FULL.
  - IDLE: go to REQ next cycle.
  - REQ: ifu_req_o=1 and ifu_addr_o=fetch_pc. Both are held stable until ifu_gnt_i=1. On gnt, go to RESP.
  - RESP: ifu_req_o=0. Wait for ifu_rvalid_i. On rvalid:
    - If discard=1: drop the data, clear discard, go to REQ.
    - Otherwise, if the IF/ID register can accept this cycle (if_hold_flag_i=0): load it directly, fetch_pc+=4, go to REQ.
    - Otherwise: store the word and its PC in a 1-entry buffer, go to FULL.
  - FULL: when if_hold_flag_i=0, move the buffer into IF/ID, fetch_pc+=4, go to REQ.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32. ifu_addr_o[1:0] is always 2'b00; jump_addr_i[1:0] is forced to 0.
- Redirect (jump_flag_i=1), which has priority over hold:
  - REQ before gnt: the address is not changed. Set pending-redirect and latch the target. When gnt arrives, set discard and load fetch_pc with the target.
  - REQ in the same cycle as gnt: same handling (discard set, fetch_pc=target).
  - RESP: set discard and fetch_pc=target. If rvalid arrives in the same cycle, that data is dropped, discard stays clear, and the FSM goes to REQ.
  - IDLE/FULL: clear the buffer, fetch_pc=target, go to REQ.
  - A second redirect before the first completes overwrites the latched target.
- IF/ID register, priority rst > clean_flag_i > if_hold_flag_i > load:
  - clean: instr_rdata_o=NOP_INSTR, instr_valid_o=0, timer_interrupt_o=0; pc_o keeps its previous value.
  - hold: all outputs keep their values.
  - load: if an instruction is available this cycle (direct from RESP or from FULL), drive instr, pc, valid=1 and timer_interrupt_o=timer_interrupt_i. Otherwise drive NOP_INSTR with valid=0 and timer_interrupt_o=0. A bubble never carries the interrupt.
- clean_flag_i without jump_flag_i does not affect the FSM; an outstanding fetch completes normally.
- if_busy_o=1 in REQ or RESP, and in IDLE after reset; 0 in FULL.
- Throughput with a zero-wait memory (gnt in the REQ cycle, rvalid next cycle): one instruction every 2 cycles.

Test Plan:
- Reset release, memory with gnt immediate and rvalid +1 cycle, rdata=0x00500093 at 0x80000000 -> ifu_addr_o=0x80000000 in cycle 1; instr_rdata_o=0x00500093, pc_o=0x80000000, instr_valid_o=1 two edges later; next request to 0x80000004.
- gnt delayed 3 cycles -> ifu_req_o and ifu_addr_o stay constant for all 4 cycles; instr_valid_o=0 with NOP_INSTR until data arrives.
- if_hold_flag_i=1 while rvalid arrives -> word buffered, FSM in FULL, outputs frozen; on hold release the buffered word appears with its PC, then a request to PC+4.
- jump_flag_i=1 with jump_addr_i=0x80000100 during RESP, rvalid 2 cycles later -> that response is dropped; next ifu_addr_o=0x80000100; first valid output has pc_o=0x80000100.
- jump_flag_i=1 in the same cycle as rvalid, and again in REQ before gnt -> both stale words dropped, no valid output from the old path, final fetch is at the last target; jump_addr_i=0x80000102 fetches 0x80000100.
- clean_flag_i=1 with if_hold_flag_i=1 and timer_interrupt_i=1 -> instr_rdata_o=0x00000013, instr_valid_o=0, timer_interrupt_o=0. fetch_pc=0xFFFFFFFC -> next fetch address 0x00000000.
